// File: rtl/sccb_master_v2.sv
// SCCB (3-wire) master: issues register writes and two-phase register reads.
//
// Parameters
//   CLK_DIV    : clk cycles per SCCB quarter-bit (2..65535)
//   ADDR_BYTES : register-address bytes per frame (1 or 2)
// Ports
//   clk, reset_n           : system clock, async active-low reset
//   start, rw              : transaction request (sampled in IDLE), 0 = write / 1 = read
//   slave_addr, reg_addr   : 7-bit device ID, register address (MSB byte first)
//   wdata / rdata          : write byte / last completed read byte
//   busy, done, nack       : in-flight flag, completion pulse, don't-care bit seen high
//   cs                     : active-low chip select, low for the whole frame (incl. GAP)
//   sio_c, sio_d_o,
//   sio_d_oe, sio_d_i      : SCCB clock, data out, data output enable, data in
module sccb_master_v2 #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned ADDR_BYTES = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    rw,
    input  logic [6:0]              slave_addr,
    input  logic [8*ADDR_BYTES-1:0] reg_addr,
    input  logic [7:0]              wdata,
    output logic [7:0]              rdata,
    output logic                    busy,
    output logic                    done,
    output logic                    nack,
    output logic                    cs,
    output logic                    sio_c,
    output logic                    sio_d_o,
    output logic                    sio_d_oe,
    input  logic                    sio_d_i
);

    localparam int unsigned    DivW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLoad = DivW'(CLK_DIV - 1);
    localparam int unsigned    AddrW    = 8 * ADDR_BYTES;
    localparam logic           LastByte = 1'(ADDR_BYTES - 1);

    typedef enum logic [3:0] {
        StIdle, StStart, StId, StAddr, StWdata, StRdata, StNa, StStop, StGap
    } state_e;

    state_e            state_q, state_d;
    logic [DivW-1:0]   div_q, div_d;     // cycles left in the current quarter
    logic [1:0]        qtr_q, qtr_d;     // quarter index within a cell / START / STOP / GAP
    logic [3:0]        bit_q, bit_d;     // bit index within a byte, 8 = don't-care bit
    logic              byte_q, byte_d;   // address byte index
    logic              phase2_q, phase2_d;
    logic              rw_q, rw_d;
    logic [6:0]        id_q, id_d;
    logic [AddrW-1:0]  reg_q, reg_d;     // shifts left so the next byte is always on top
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        rx_q, rx_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              nack_q, nack_d;
    logic              done_q, done_d;
    // Low only during reset and the first cycle after it: keeps sio_d undriven
    // while in reset and holds off the first start by one edge.
    logic              rdy_q;

    logic              qtr_end, sample, cell_end;
    logic [7:0]        tx_byte;
    logic [2:0]        bit_idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            div_q    <= '0;
            qtr_q    <= '0;
            bit_q    <= '0;
            byte_q   <= 1'b0;
            phase2_q <= 1'b0;
            rw_q     <= 1'b0;
            id_q     <= '0;
            reg_q    <= '0;
            wdata_q  <= '0;
            rx_q     <= '0;
            rdata_q  <= '0;
            nack_q   <= 1'b0;
            done_q   <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            qtr_q    <= qtr_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            phase2_q <= phase2_d;
            rw_q     <= rw_d;
            id_q     <= id_d;
            reg_q    <= reg_d;
            wdata_q  <= wdata_d;
            rx_q     <= rx_d;
            rdata_q  <= rdata_d;
            nack_q   <= nack_d;
            done_q   <= done_d;
            rdy_q    <= 1'b1;
        end
    end

    assign qtr_end  = (div_q == '0);
    assign sample   = qtr_end && (qtr_q == 2'd2);
    assign cell_end = qtr_end && (qtr_q == 2'd3);

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        qtr_d    = qtr_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        phase2_d = phase2_q;
        rw_d     = rw_q;
        id_d     = id_q;
        reg_d    = reg_q;
        wdata_d  = wdata_q;
        rx_d     = rx_q;
        rdata_d  = rdata_q;
        nack_d   = nack_q;
        done_d   = 1'b0;

        if (state_q != StIdle) begin
            div_d = qtr_end ? DivLoad : div_q - DivW'(1);
            if (qtr_end) begin
                qtr_d = qtr_q + 2'd1;
            end
        end

        case (state_q)
            StIdle: begin
                if (start && rdy_q) begin
                    state_d  = StStart;
                    div_d    = DivLoad;
                    qtr_d    = '0;
                    bit_d    = '0;
                    byte_d   = 1'b0;
                    phase2_d = 1'b0;
                    rw_d     = rw;
                    id_d     = slave_addr;
                    reg_d    = reg_addr;
                    wdata_d  = wdata;
                    nack_d   = 1'b0;
                end
            end
            StStart: begin
                if (qtr_end && qtr_q == 2'd1) begin
                    state_d = StId;
                    qtr_d   = '0;
                    bit_d   = '0;
                end
            end
            StId, StAddr, StWdata: begin
                if (sample && bit_q == 4'd8 && sio_d_i) begin
                    nack_d = 1'b1;
                end
                if (cell_end) begin
                    if (bit_q != 4'd8) begin
                        bit_d = bit_q + 4'd1;
                    end else begin
                        bit_d = '0;
                        if (state_q == StId) begin
                            state_d = phase2_q ? StRdata : StAddr;
                            byte_d  = 1'b0;
                        end else if (state_q == StAddr) begin
                            reg_d = reg_q << 8;
                            if (byte_q == LastByte) begin
                                state_d = rw_q ? StStop : StWdata;
                            end else begin
                                byte_d = byte_q + 1'b1;
                            end
                        end else begin
                            state_d = StStop;
                        end
                    end
                end
            end
            StRdata: begin
                if (sample) begin
                    rx_d = {rx_q[6:0], sio_d_i};
                end
                if (cell_end) begin
                    if (bit_q == 4'd7) begin
                        state_d = StNa;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            StNa: begin
                if (cell_end) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (qtr_end && qtr_q == 2'd2) begin
                    qtr_d = '0;
                    if (rw_q && !phase2_q) begin
                        state_d = StGap;
                    end else begin
                        state_d = StIdle;
                        div_d   = '0;
                        done_d  = 1'b1;
                        if (phase2_q) begin
                            rdata_d = rx_q;
                        end
                    end
                end
            end
            StGap: begin
                if (cell_end) begin
                    state_d  = StStart;
                    phase2_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Pad outputs decode straight from registered state, so they only move on clk edges.
    always_comb begin
        tx_byte  = 8'hFF;
        sio_c    = 1'b1;
        sio_d_o  = 1'b1;
        sio_d_oe = 1'b1;
        bit_idx  = 3'd7 - bit_q[2:0];

        case (state_q)
            StId:    tx_byte = {id_q, phase2_q};
            StAddr:  tx_byte = reg_q[AddrW-1 -: 8];
            StWdata: tx_byte = wdata_q;
            default: tx_byte = 8'hFF;
        endcase

        case (state_q)
            StIdle: begin
                sio_d_oe = rdy_q;
            end
            StStart: begin
                sio_d_o = (qtr_q == 2'd0);
            end
            StId, StAddr, StWdata: begin
                sio_c = qtr_q[1];
                if (bit_q == 4'd8) begin
                    sio_d_oe = 1'b0;
                end else begin
                    sio_d_o = tx_byte[bit_idx];
                end
            end
            StRdata: begin
                sio_c    = qtr_q[1];
                sio_d_oe = 1'b0;
            end
            StNa: begin
                sio_c = qtr_q[1];
            end
            StStop: begin
                sio_c   = (qtr_q != 2'd0);
                sio_d_o = (qtr_q == 2'd2);
            end
            default: begin
                sio_c   = 1'b1;
                sio_d_o = 1'b1;
            end
        endcase
    end

    assign cs    = (state_q == StIdle);
    assign busy  = (state_q != StIdle);
    assign done  = done_q;
    assign nack  = nack_q;
    assign rdata = rdata_q;

endmodule
